// File: rtl/serial_pattern_generator.sv
// Serial pattern generator: latches pattern/len/reps on start and shifts
// the pattern out MSB-first, repeated back-to-back, then pulses done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   pattern, len, reps  transmission parameters, latched on acceptance
//   abort               terminate an in-progress transmission
//   dout, dout_valid    serial bit and its qualifier
//   busy                high from acceptance until completion or abort
//   done                one-cycle pulse on normal completion
//   err                 one-cycle pulse when a start request is rejected
module serial_pattern_generator #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5,
   parameter int REP_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [REP_W-1:0]   reps,
   input  logic               abort,
   output logic               dout,
   output logic               dout_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_n;
   logic [MAX_LEN-1:0] pat_q, pat_n;
   logic [LEN_W-1:0]   len_q, len_n;
   logic [LEN_W-1:0]   idx_q, idx_n;
   logic [REP_W-1:0]   rep_q, rep_n;

   logic dout_n, valid_n, busy_n, done_n, err_n;
   logic req_ok;

   // Shift-based select keeps the index width independent of MAX_LEN.
   function automatic logic bit_at(
      input logic [MAX_LEN-1:0] p,
      input logic [LEN_W-1:0]   i
   );
      logic [MAX_LEN-1:0] s;
      s = p >> i;
      return s[0];
   endfunction

   assign req_ok = (len != '0) &&
                   (len <= LEN_W'(MAX_LEN)) &&
                   (reps != '0);

   // idx_q always names the bit currently on dout, so the first bit is
   // driven straight from the input pattern at the accepting edge.
   always_comb begin
      state_n = state_q;
      pat_n   = pat_q;
      len_n   = len_q;
      idx_n   = idx_q;
      rep_n   = rep_q;
      dout_n  = 1'b0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (req_ok) begin
                  pat_n   = pattern;
                  len_n   = len;
                  idx_n   = len - 1'b1;
                  rep_n   = reps;
                  state_n = SHIFT;
                  busy_n  = 1'b1;
                  valid_n = 1'b1;
                  dout_n  = bit_at(pattern, len - 1'b1);
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_n = IDLE;
            end else if (idx_q == '0 && rep_q == REP_W'(1)) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else if (idx_q == '0) begin
               idx_n   = len_q - 1'b1;
               rep_n   = rep_q - 1'b1;
               busy_n  = 1'b1;
               valid_n = 1'b1;
               dout_n  = bit_at(pat_q, len_q - 1'b1);
            end else begin
               idx_n   = idx_q - 1'b1;
               busy_n  = 1'b1;
               valid_n = 1'b1;
               dout_n  = bit_at(pat_q, idx_q - 1'b1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pat_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         rep_q      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_n;
         pat_q      <= pat_n;
         len_q      <= len_n;
         idx_q      <= idx_n;
         rep_q      <= rep_n;
         dout       <= dout_n;
         dout_valid <= valid_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Testbench for serial_pattern_generator: scenario tasks checked against
// a bit-queue reference built from pattern/len/reps.
module tb_serial_pattern_generator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] pattern = '0;
   logic [4:0]  len = '0;
   logic [3:0]  reps = '0;
   logic        dout, dout_valid, busy, done, err;

   logic [4:0]  obs;
   logic [4:0]  exp;
   int          tests = 0;
   int          fails = 0;

   serial_pattern_generator #(
      .MAX_LEN(16),
      .LEN_W(5),
      .REP_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .pattern(pattern),
      .len(len),
      .reps(reps),
      .abort(abort),
      .dout(dout),
      .dout_valid(dout_valid),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   // {busy, dout_valid, dout, done, err}
   assign obs = {busy, dout_valid, dout, done, err};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      pattern = 16'hFFFF;
      len = 5'd4;
      reps = 4'd1;
      tick();
      tick();
      exp = 5'b00000;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL reset_hold: got %b want %b", obs, exp);
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL reset_release: got %b want %b", obs, exp);
      end
   endtask

   task automatic test_transmission(
      input logic [15:0] p,
      input int          l,
      input int          r,
      input bit          noisy,
      input string       name
   );
      bit q[$];
      int n;
      for (int k = 0; k < r; k++)
         for (int b = l - 1; b >= 0; b--)
            q.push_back(p[b]);
      n = q.size();
      pattern = p;
      len = l[4:0];
      reps = r[3:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) tick();
         exp = {1'b1, 1'b1, q[i], 1'b0, 1'b0};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL %s bit %0d: got %b want %b", name, i, obs, exp);
         end
         if (noisy) begin
            pattern = 16'($urandom);
            len = 5'($urandom);
            reps = 4'($urandom);
            start = (i + 1 < n) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      start = 1'b0;
      tick();
      exp = 5'b00010;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s done: got %b want %b", name, obs, exp);
      end
      tick();
      exp = 5'b00000;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s idle: got %b want %b", name, obs, exp);
      end
   endtask

   task automatic test_illegal();
      logic [4:0] bad_len [3] = '{5'd0, 5'd17, 5'd5};
      logic [3:0] bad_rep [3] = '{4'd1, 4'd1, 4'd0};
      for (int c = 0; c < 3; c++) begin
         pattern = 16'hA5A5;
         len = bad_len[c];
         reps = bad_rep[c];
         start = 1'b1;
         tick();
         start = 1'b0;
         exp = 5'b00001;
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL illegal%0d err: got %b want %b", c, obs, exp);
         end
         tick();
         exp = 5'b00000;
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL illegal%0d after: got %b want %b", c, obs, exp);
         end
      end
   endtask

   task automatic test_abort();
      int ones = 0;
      pattern = 16'hFFFF;
      len = 5'd16;
      reps = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick();
         exp = 5'b11100;
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL abort bit %0d: got %b want %b", i, obs, exp);
         end
         if (dout && dout_valid) ones++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp = 5'b00000;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL abort_stop: got %b want %b", obs, exp);
      end
      tests++;
      if (ones !== 7) begin
         fails++;
         $display("FAIL abort_ones: got %0d want 7", ones);
      end
      tick();
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL abort_no_done: got %b want %b", obs, exp);
      end
      pattern = 16'h0002;
      len = 5'd2;
      reps = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp = 5'b11100;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL abort_restart0: got %b want %b", obs, exp);
      end
      tick();
      exp = 5'b11000;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL abort_restart1: got %b want %b", obs, exp);
      end
      tick();
      exp = 5'b00010;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL abort_restart_done: got %b want %b", obs, exp);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [15:0] p;
      p = 16'($urandom);
      pattern = p;
      len = 5'd8;
      reps = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         exp = {1'b1, 1'b1, p[7 - i], 1'b0, 1'b0};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL resetmid bit %0d: got %b want %b", i, obs, exp);
         end
         if (i == 1) begin
            start = 1'b1;
            pattern = ~p;
            len = 5'd3;
         end else begin
            start = 1'b0;
         end
      end
      rst_n = 1'b0;
      tick();
      exp = 5'b00000;
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL resetmid_clear: got %b want %b", obs, exp);
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL resetmid_idle: got %b want %b", obs, exp);
      end
      test_transmission(16'($urandom), 8, 1, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int t = 0; t < 20; t++)
         test_transmission(16'($urandom), $urandom_range(1, 16),
                           $urandom_range(1, 4), 1'b1, "random");
   endtask

   initial begin
      test_reset();
      test_transmission(16'b10110, 5, 1, 1'b0, "single");
      test_transmission(16'b10, 2, 3, 1'b0, "back_to_back");
      test_illegal();
      test_abort();
      test_reset_mid();
      test_transmission(16'h8001, 16, 15, 1'b0, "max_len");
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_pattern_generator.md
# serial_pattern_generator

Serial bit-pattern transmitter that drives the single-bit `din` stream consumed by the Mealy sequence detector. It latches a parallel pattern, a length and a repeat count on a start pulse. It then shifts the pattern out MSB-first, one bit per clock, repeating it back-to-back, and signals completion. It is used as the stimulus source in detector subsystem benches and as the on-chip test-pattern source feeding the detector.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits (≥2).
- `LEN_W`, 5: width of `len`. Must satisfy 2^LEN_W > MAX_LEN.
- `REP_W`, 4: width of `reps`.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `pattern`  in  MAX_LEN  bits to send; `pattern[len-1]` goes first, `pattern[0]` goes last.
- `len`  in  LEN_W  number of bits per pattern, legal range 1..MAX_LEN.
- `reps`  in  REP_W  number of back-to-back pattern repetitions, legal range 1..2^REP_W-1.
- `abort`  in  1  terminate an in-progress transmission.
- `dout`  out  1  serial bit (feeds detector `din`).
- `dout_valid`  out  1  high while `dout` carries a pattern bit.
- `busy`  out  1  high from acceptance until completion or abort.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse when a start request is rejected.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (`rst_n`=0 at an edge): state=IDLE. `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `err`=0. Internal counters are cleared. Reset overrides everything, including mid-transmission.
- **IDLE**
  - `start`=1 with legal `len` and `reps`: latch `pattern`, `len` and `reps`; load the bit index to `len-1` and the repetition counter to `reps`; go to SHIFT.
  - `start`=1 with `len`=0, `len`>MAX_LEN, or `reps`=0: stay in IDLE and pulse `err` for one cycle. `busy` stays 0.
  - `abort` is ignored in IDLE.
- **SHIFT**
  - Each cycle, present `pattern_latched[idx]` on `dout` with `dout_valid`=1.
  - If `idx`=0 and repetitions remain, reload `idx`=`len-1` with no gap cycle.
  - After the last bit of the last repetition, go to DONE.
- **DONE**
  - Lasts one cycle: `done`=1, `busy`=0, `dout`=0, `dout_valid`=0.
  - Then go to IDLE.
  - `start` arriving in DONE is ignored.
- `start` is ignored while `busy`=1. Input changes after acceptance have no effect on the transmission in progress.
- `abort`=1 in SHIFT: at the next edge go to IDLE, with `dout`=0, `dout_valid`=0, `busy`=0. No `done` pulse is issued.
- If `abort` and the final bit coincide, abort wins: no `done` pulse.
- `dout` is 0 whenever `dout_valid`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- `start` sampled high at edge k (IDLE, legal inputs):
  - `busy`=1 from edge k.
  - First bit appears on `dout` with `dout_valid`=1 from edge k. It is visible in the cycle after k and sampled by the detector at edge k+1.
- Bit n (0-based, counting across repetitions) is driven between edge k+n and edge k+n+1.
- Total valid bits = `len`×`reps`, with no bubbles.
- The last bit is driven from edge k+N-1, where N = `len`×`reps`.
- At edge k+N: `done`=1, `busy`=0, `dout_valid`=0.
- At edge k+N+1: `done`=0, state=IDLE. A new `start` is accepted at edge k+N+1 at the earliest.
- `err` is high for exactly the one cycle following the rejecting edge.
- `abort` sampled at edge j (k < j < k+N): at edge j, `dout_valid`=0 and `busy`=0. The bit that would have been driven from edge j is suppressed.
- `rst_n`=0 at any edge: all outputs are at their reset values after that edge.

## Test plan
- **Single pattern:** `pattern`=0b10110, `len`=5, `reps`=1, `start` at edge k.
  - `dout` = 1,0,1,1,0 in the cycles after edges k..k+4, with `dout_valid`=1 throughout.
  - `done`=1 after edge k+5 only.
  - A connected detector flags 10110 on its final bit.
- **Back-to-back repetitions:** `pattern`=0b10, `len`=2, `reps`=3.
  - `dout` = 101010 over six contiguous cycles with no gap.
  - `busy` is high for exactly 6 cycles, followed by a single `done`.
- **Illegal requests:** `start` with `len`=0, then `start` with `len`=17 (MAX_LEN=16), then `start` with `reps`=0.
  - Each produces a one-cycle `err` pulse.
  - `busy`, `dout_valid` and `done` stay 0.
- **Abort mid-transmission:** `pattern`=0xFFFF, `len`=16, `reps`=2, `abort` at edge k+7.
  - Exactly 7 ones are emitted.
  - `dout_valid`=0 and `busy`=0 after edge k+7; no `done`.
  - A new `start` at edge k+9 is accepted.
- **Reset mid-transmission, plus start while busy:** start a `len`=8 transmission, pulse `start` again at edge k+2, then drive `rst_n`=0 at edge k+4.
  - The second `start` has no effect.
  - After edge k+4, all outputs are 0 and state is IDLE.
  - After `rst_n` returns to 1, a fresh `start` transmits normally.
- **Maximum length:** `pattern`=0x8001, `len`=16, `reps`=15.
  - 240 valid bits are emitted, with a 1 at each pattern's first and last bit position.
  - `done` is asserted exactly at edge k+240.
